// File: rtl/cnu_minsum_serial.sv
// Serial min-sum check-node unit.
// Collects DC variable-to-check LLRs (one per cycle), tracks the two smallest
// magnitudes, the index of the smallest and the sign parity, then emits DC
// check-to-variable LLRs in the same edge order.
// Optional build macro: CNU_OFFSET_EN (offset min-sum, magnitude reduced by OFFSET).
module cnu_minsum_serial #(
  parameter int DC     = 6,
  parameter int OFFSET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic signed [7:0] in_msg,
  output logic              in_ready,
  output logic              out_valid,
  output logic signed [7:0] out_msg,
  output logic              out_last,
  input  logic              out_ready
);

  localparam int DATA_W = 8;
  localparam int MAG_W  = DATA_W - 1;
  localparam int IDX_W  = (DC > 1) ? $clog2(DC) : 1;
  localparam int SGN_N  = 1 << IDX_W;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DC - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [MAG_W-1:0] MAG_MAX  = '1;

  // Elaboration-time sanity check of the configuration.
  generate
    if (DC < 2 || DC > 16 || OFFSET < 0 || OFFSET > 127) begin : g_cfg_chk
      $error("cnu_minsum_serial: illegal DC or OFFSET");
    end
  endgenerate

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

  // Saturating absolute value: -128 maps to 127 so magnitudes fit in MAG_W bits.
  function automatic logic [MAG_W-1:0] sat_abs(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] neg;
    neg = -x;
    if (x[DATA_W-1] && (x[MAG_W-1:0] == '0)) return MAG_MAX;
    else if (x[DATA_W-1])                    return neg[MAG_W-1:0];
    else                                     return x[MAG_W-1:0];
  endfunction

`ifdef CNU_OFFSET_EN
  // Offset min-sum: subtract OFFSET and clamp at zero before the sign is applied.
  function automatic logic [MAG_W-1:0] apply_offset(input logic [MAG_W-1:0] mag);
    if (int'(mag) > OFFSET) return MAG_W'(int'(mag) - OFFSET);
    else                    return '0;
  endfunction
`else
  // Plain min-sum: magnitude passes through unchanged.
  function automatic logic [MAG_W-1:0] apply_offset(input logic [MAG_W-1:0] mag);
    return mag;
  endfunction
`endif

  // Apply a sign to a non-negative magnitude; zero stays zero for either sign.
  function automatic logic signed [DATA_W-1:0] apply_sign(input logic s,
                                                           input logic [MAG_W-1:0] mag);
    logic signed [DATA_W-1:0] pos;
    pos = {1'b0, mag};
    return s ? -pos : pos;
  endfunction

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx1_q, idx1_d;
  logic [MAG_W-1:0]   min1_q, min1_d;
  logic [MAG_W-1:0]   min2_q, min2_d;
  logic               parity_q;
  logic [SGN_N-1:0]   sign_q;

  logic               in_fire;
  logic               out_fire;
  logic [MAG_W-1:0]   mag_in;
  logic [MAG_W-1:0]   emit_mag;
  logic               emit_sgn;

  // Handshakes and the running two-minimum update for the incoming edge.
  always_comb begin
    in_fire  = in_valid  && (state_q == COLLECT);
    out_fire = out_ready && (state_q == EMIT);
    mag_in   = sat_abs(in_msg);
    min1_d   = min1_q;
    min2_d   = min2_q;
    idx1_d   = idx1_q;
    if (mag_in < min1_q) begin
      min2_d = min1_q;
      min1_d = mag_in;
      idx1_d = idx_q;
    end else if (mag_in < min2_q) begin
      min2_d = mag_in;
    end
  end

  // Output message for the current edge; outputs are zero outside EMIT.
  always_comb begin
    emit_mag  = apply_offset((idx_q == idx1_q) ? min2_q : min1_q);
    emit_sgn  = parity_q ^ sign_q[idx_q];
    in_ready  = (state_q == COLLECT);
    out_valid = (state_q == EMIT);
    out_msg   = '0;
    out_last  = 1'b0;
    if (state_q == EMIT) begin
      out_msg  = apply_sign(emit_sgn, emit_mag);
      out_last = (idx_q == IDX_LAST);
    end
  end

  // Collect/emit FSM with edge counter and per-frame accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= COLLECT;
      idx_q    <= '0;
      idx1_q   <= '0;
      min1_q   <= MAG_MAX;
      min2_q   <= MAG_MAX;
      parity_q <= 1'b0;
      sign_q   <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (in_fire) begin
            sign_q[idx_q] <= in_msg[DATA_W-1];
            parity_q      <= parity_q ^ in_msg[DATA_W-1];
            min1_q        <= min1_d;
            min2_q        <= min2_d;
            idx1_q        <= idx1_d;
            if (idx_q == IDX_LAST) begin
              state_q <= EMIT;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + IDX_ONE;
            end
          end
        end
        EMIT: begin
          if (out_fire) begin
            if (idx_q == IDX_LAST) begin
              state_q  <= COLLECT;
              idx_q    <= '0;
              idx1_q   <= '0;
              min1_q   <= MAG_MAX;
              min2_q   <= MAG_MAX;
              parity_q <= 1'b0;
            end else begin
              idx_q <= idx_q + IDX_ONE;
            end
          end
        end
        default: begin
          state_q <= COLLECT;
          idx_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnu_minsum_serial.sv
// Directed self-checking bench for cnu_minsum_serial (DC=6, OFFSET=1).
// Expected tables follow the build: offset values when CNU_OFFSET_EN is defined.
module tb_cnu_minsum_serial;

  typedef int vec_t[6];

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic signed [7:0] in_msg = '0;
  logic              in_ready;
  logic              out_valid;
  logic signed [7:0] out_msg;
  logic              out_last;
  logic              out_ready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  cnu_minsum_serial #(.DC(6), .OFFSET(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_msg    (in_msg),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_msg   (out_msg),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive one frame of inputs on falling edges, optionally with random idle gaps.
  task automatic send_frame(input vec_t v, input bit gaps, input string name);
    int i = 0;
    int guard = 0;
    while (i < 6 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (gaps && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        in_msg   = 8'($urandom);
      end else begin
        check({name, " in_ready"}, int'(in_ready), 1);
        in_valid = 1'b1;
        in_msg   = 8'(v[i]);
        i++;
      end
    end
    if (i < 6) check({name, " send timeout"}, i, 6);
  endtask

  // Collect one frame of outputs; optionally stall out_ready for 3 cycles at stall_at.
  task automatic recv_frame(input vec_t e, input int stall_at, input string name);
    int k = 0;
    int stall = 0;
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_msg   = 8'sh81;
    check({name, " latency out_valid"}, int'(out_valid), 1);
    while (k < 6 && guard < 50) begin
      guard++;
      check($sformatf("%s out_msg[%0d]", name, k), int'(out_msg), e[k]);
      check($sformatf("%s out_last[%0d]", name, k), int'(out_last), (k == 5) ? 1 : 0);
      check($sformatf("%s in_ready emit[%0d]", name, k), int'(in_ready), 0);
      if (k == stall_at && stall < 3) begin
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = 1'b1;
        k++;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (k < 6) check({name, " recv timeout"}, k, 6);
    check({name, " idle in_ready"}, int'(in_ready), 1);
    check({name, " idle out_valid"}, int'(out_valid), 0);
    check({name, " idle out_msg"}, int'(out_msg), 0);
    check({name, " idle out_last"}, int'(out_last), 0);
  endtask

  task automatic run_frame(input vec_t v, input vec_t e, input bit gaps,
                           input int stall_at, input string name);
    send_frame(v, gaps, name);
    recv_frame(e, stall_at, name);
  endtask

  vec_t v_basic = '{5, -3, 7, 2, -9, 4};
  vec_t v_ones  = '{1, 1, 1, 1, 1, 1};
  vec_t v_neg   = '{-128, -128, -128, -128, -128, -128};
  vec_t v_par   = '{-128, 1, 1, 1, 1, 1};
  vec_t v_tie   = '{4, 4, 10, 10, 10, 10};
  vec_t v_zero  = '{0, -5, 6, -7, 8, 9};
`ifdef CNU_OFFSET_EN
  vec_t e_basic = '{1, -1, 1, 2, -1, 1};
  vec_t e_ones  = '{0, 0, 0, 0, 0, 0};
  vec_t e_neg   = '{-126, -126, -126, -126, -126, -126};
  vec_t e_par   = '{0, 0, 0, 0, 0, 0};
  vec_t e_tie   = '{3, 3, 3, 3, 3, 3};
  vec_t e_zero  = '{4, 0, 0, 0, 0, 0};
`else
  vec_t e_basic = '{2, -2, 2, 3, -2, 2};
  vec_t e_ones  = '{1, 1, 1, 1, 1, 1};
  vec_t e_neg   = '{-127, -127, -127, -127, -127, -127};
  vec_t e_par   = '{1, -1, -1, -1, -1, -1};
  vec_t e_tie   = '{4, 4, 4, 4, 4, 4};
  vec_t e_zero  = '{5, 0, 0, 0, 0, 0};
`endif

  initial begin
    #1;
    check("reset in_ready", int'(in_ready), 1);
    check("reset out_valid", int'(out_valid), 0);
    check("reset out_msg", int'(out_msg), 0);
    check("reset out_last", int'(out_last), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_frame(v_basic, e_basic, 1'b0, -1, "basic");
    run_frame(v_ones,  e_ones,  1'b0, -1, "ones");
    run_frame(v_neg,   e_neg,   1'b0, -1, "sat");
    run_frame(v_par,   e_par,   1'b0, -1, "parity");
    run_frame(v_tie,   e_tie,   1'b0, -1, "tie");
    run_frame(v_zero,  e_zero,  1'b0, -1, "zero");
    run_frame(v_basic, e_basic, 1'b0, 2,  "stall");
    run_frame(v_basic, e_basic, 1'b1, -1, "gaps");
    run_frame(v_par,   e_par,   1'b1, 4,  "gaps_stall");

    // Abort a partial frame whose values would change the result if kept.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_msg   = -8'sd1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst in_ready", int'(in_ready), 1);
    check("midrst out_valid", int'(out_valid), 0);
    check("midrst out_msg", int'(out_msg), 0);
    @(negedge clk);
    rst = 1'b0;
    run_frame(v_basic, e_basic, 1'b0, -1, "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
